// File: rtl/rv32i_dmem_responder.sv
// Data memory for the RV32I load/store port: byte/half/word accesses, little-endian, with sign or zero extension on loads.
// Latency: the response is valid WAIT_CYCLES+1 cycles after acceptance. rsp_* is held while rsp_ready=0, and req_ready stays 0 until the response is taken.
module rv32i_dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] acc_count
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  wcnt;
  logic        a_we;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic [2:0]  a_f3;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic          in_range;
  logic [31:0]   rd_word;
  logic          f3_bad;
  logic          misal;
  logic          acc_err;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   ld_data;
  logic          do_access;
  logic          mem_we;

  assign idx       = a_addr[AW+1:2];
  // Upper address bits must be zero; the array is never aliased.
  assign in_range  = (a_addr[31:AW+2] == '0);
  assign rd_word   = mem[idx];
  assign do_access = (state == WAIT) && (wcnt == 4'd0);
  assign mem_we    = do_access && a_we && !acc_err;

  always_comb begin
    f3_bad  = 1'b0;
    misal   = 1'b0;
    be      = 4'b0000;
    wd      = a_wdata;
    byte_v  = rd_word[7:0];
    half_v  = a_addr[1] ? rd_word[31:16] : rd_word[15:0];
    ld_data = rd_word;
    case (a_addr[1:0])
      2'd0:    byte_v = rd_word[7:0];
      2'd1:    byte_v = rd_word[15:8];
      2'd2:    byte_v = rd_word[23:16];
      default: byte_v = rd_word[31:24];
    endcase
    case (a_f3[1:0])
      2'b00: begin
        be      = 4'b0001 << a_addr[1:0];
        wd      = {4{a_wdata[7:0]}};
        ld_data = {{24{~a_f3[2] & byte_v[7]}}, byte_v};
      end
      2'b01: begin
        be      = a_addr[1] ? 4'b1100 : 4'b0011;
        wd      = {2{a_wdata[15:0]}};
        misal   = a_addr[0];
        ld_data = {{16{~a_f3[2] & half_v[15]}}, half_v};
      end
      2'b10: begin
        be      = 4'b1111;
        misal   = |a_addr[1:0];
        ld_data = rd_word;
      end
      default: f3_bad = 1'b1;
    endcase
    // Unsigned variants exist only for byte/half loads.
    if (a_f3[2] && (a_we || a_f3[1])) f3_bad = 1'b1;
    acc_err = f3_bad || misal || !in_range;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      acc_count <= 16'd0;
      wcnt      <= 4'd0;
      a_we      <= 1'b0;
      a_addr    <= 32'd0;
      a_wdata   <= 32'd0;
      a_f3      <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_we      <= req_we;
            a_addr    <= req_addr;
            a_wdata   <= req_wdata;
            a_f3      <= req_funct3;
            wcnt      <= 4'(WAIT_CYCLES);
            req_ready <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (wcnt != 4'd0) begin
            wcnt <= wcnt - 4'd1;
          end else begin
            rsp_rdata <= (acc_err || a_we) ? 32'd0 : ld_data;
            rsp_err   <= acc_err;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            acc_count <= acc_count + 16'd1;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Directed bench for rv32i_dmem_responder: vector table plus backpressure and mid-access reset sequences.
module tb_rv32i_dmem_responder;

  localparam int DEPTH = 256;
  localparam int WC    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] acc_count;

  int errors = 0;
  int checks = 0;
  int exp_acc = 0;

  always #5 clk = ~clk;

  rv32i_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .acc_count(acc_count)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One complete access with rsp_ready held high; lat counts edges from acceptance to rsp_valid.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3, output logic [31:0] rd, output logic er,
                           output int lat);
    int guard;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk); #1;
    exp_acc++;
  endtask

  vec_t vecs[$];
  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [31:0] held;
  int          guard;

  function automatic vec_t mk(logic we, logic [31:0] a, logic [31:0] w, logic [2:0] f,
                              logic [31:0] r, logic e);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = w; v.f3 = f; v.exp_rdata = r; v.exp_err = e;
    return v;
  endfunction

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
    rsp_ready = 1'b1;
    rst = 1'b0;
    #10;
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err",   {31'd0, rsp_err}, 32'd0);
    check("reset_acc_count", {16'd0, acc_count}, 32'd0);
    rst = 1'b1;

    vecs.push_back(mk(1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 0));
    vecs.push_back(mk(0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 32'h20, 32'h00000000, 3'b010, 32'h0, 0));
    vecs.push_back(mk(1, 32'h21, 32'h00000085, 3'b000, 32'h0, 0));
    vecs.push_back(mk(0, 32'h20, 32'h0,        3'b010, 32'h00008500, 0));
    vecs.push_back(mk(0, 32'h21, 32'h0,        3'b000, 32'hFFFFFF85, 0));
    vecs.push_back(mk(0, 32'h21, 32'h0,        3'b100, 32'h00000085, 0));
    vecs.push_back(mk(1, 32'h22, 32'hFFFF8001, 3'b001, 32'h0, 0));
    vecs.push_back(mk(0, 32'h22, 32'h0,        3'b001, 32'hFFFF8001, 0));
    vecs.push_back(mk(0, 32'h22, 32'h0,        3'b101, 32'h00008001, 0));
    vecs.push_back(mk(0, 32'h20, 32'h0,        3'b010, 32'h80018500, 0));
    vecs.push_back(mk(1, 32'h30, 32'h11111111, 3'b010, 32'h0, 0));
    vecs.push_back(mk(0, 32'h31, 32'h0,        3'b010, 32'h0, 1));
    vecs.push_back(mk(1, 32'h33, 32'h0000FFFF, 3'b001, 32'h0, 1));
    vecs.push_back(mk(0, 32'h30, 32'h0,        3'b010, 32'h11111111, 0));
    vecs.push_back(mk(0, DEPTH*4,  32'h0,      3'b010, 32'h0, 1));
    vecs.push_back(mk(0, 32'h30, 32'h0,        3'b011, 32'h0, 1));
    vecs.push_back(mk(1, 32'h30, 32'h22222222, 3'b100, 32'h0, 1));
    vecs.push_back(mk(0, 32'h30, 32'h0,        3'b010, 32'h11111111, 0));
    vecs.push_back(mk(0, 32'h32, 32'h0,        3'b001, 32'h00001111, 0));
    vecs.push_back(mk(1, 32'h3FC, 32'hA5A5A5A5, 3'b010, 32'h0, 0));
    vecs.push_back(mk(0, 32'h3FC, 32'h0,       3'b010, 32'hA5A5A5A5, 0));
    vecs.push_back(mk(0, 32'h80000010, 32'h0,  3'b010, 32'h0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, rd, er, lat);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d_latency", i), lat, WC + 1);
      if (i == 1) check("acc_after_roundtrip", {16'd0, acc_count}, 32'd2);
    end
    check("acc_after_table", {16'd0, acc_count}, exp_acc);

    // Backpressure: response held while a competing request is presented.
    rsp_ready = 1'b0;
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010; req_valid = 1'b1;
    @(posedge clk); #1;
    req_addr = 32'h20;
    guard = 0;
    while (!rsp_valid && guard < 50) begin @(posedge clk); #1; guard++; end
    held = rsp_rdata;
    check("bp_data", held, 32'hDEADBEEF);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp_valid_%0d", c), {31'd0, rsp_valid}, 32'd1);
      check($sformatf("bp_stable_%0d", c), rsp_rdata, held);
      check($sformatf("bp_req_ready_%0d", c), {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    exp_acc++;
    check("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
    check("bp_release_ready", {31'd0, req_ready}, 32'd1);
    check("bp_acc", {16'd0, acc_count}, exp_acc);
    repeat (WC + 3) @(posedge clk);
    #1;
    check("bp_no_ghost", {31'd0, rsp_valid}, 32'd0);

    // Reset during WAIT abandons the store and the count.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_access(1'b1, 32'h40, 32'h12345678, 3'b010, rd, er, lat);
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hAAAA5555; req_funct3 = 3'b010; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid_in_wait", {31'd0, req_ready}, 32'd0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_acc", {16'd0, acc_count}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (WC + 2) @(posedge clk);
    do_access(1'b0, 32'h40, 32'h0, 3'b010, rd, er, lat);
    check("mid_load_data", rd, 32'h12345678);
    check("mid_load_err", {31'd0, er}, 32'd0);
    check("mid_acc", {16'd0, acc_count}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
